// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: exception flag layout, fetch->decode bus
// width and the counter-width helper used by the fetch queue.
package fetch_pkg;

    localparam int EXC_W = 6;

    localparam int EXC_FLG_ADEF = 0;
    localparam int EXC_FLG_SYS  = 1;
    localparam int EXC_FLG_ALE  = 2;
    localparam int EXC_FLG_BRK  = 3;
    localparam int EXC_FLG_INE  = 4;
    localparam int EXC_FLG_INT  = 5;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    localparam int FS_TO_DS_BUS_WD = EXC_W + INST_W + PC_W;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_ring.sv
// In-order ring of fetch entries {filled, exc, inst, pc} with allocate, fill
// and read pointers plus the occupancy count.
module fetch_ring #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 6,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = fetch_pkg::cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic [EXC_W-1:0]  alloc_exc,
    input  logic              fill,
    input  logic [INST_W-1:0] fill_inst,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  q_cnt,
    output logic              head_filled,
    output logic [EXC_W-1:0]  head_exc,
    output logic [INST_W-1:0] head_inst,
    output logic [PC_W-1:0]   head_pc
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DEPTH-1:0]  filled;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [EXC_W-1:0]  exc_mem  [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    // A flush collapses the ring onto the old allocate pointer; stale filled
    // bits are harmless because q_cnt is 0 and allocation clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            filled   <= '0;
        end else if (flush) begin
            fill_ptr <= wr_ptr;
            rd_ptr   <= wr_ptr;
            q_cnt    <= '0;
        end else begin
            if (alloc) begin
                filled[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (fill) begin
                filled[fill_ptr] <= 1'b1;
                fill_ptr         <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            q_cnt <= q_cnt + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    // Payload storage carries no reset; validity lives in filled and q_cnt.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (alloc) begin
                pc_mem[wr_ptr]  <= alloc_pc;
                exc_mem[wr_ptr] <= alloc_exc;
            end
            if (fill) begin
                inst_mem[fill_ptr] <= fill_inst;
            end
        end
    end

    assign head_filled = filled[rd_ptr];
    assign head_exc    = exc_mem[rd_ptr];
    assign head_inst   = inst_mem[rd_ptr];
    assign head_pc     = pc_mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: tracks in-flight SRAM requests, buffers returned
// instructions in order and drops responses made stale by a redirect.
module if_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int EXC_W   = fetch_pkg::EXC_W
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          issue_allow,
    input  logic                          req_fire,
    input  logic [PC_W-1:0]               req_pc,
    input  logic                          inst_sram_data_ok,
    input  logic [INST_W-1:0]             inst_sram_rdata,
    input  logic                          flush,
    output logic                          fs_to_ds_valid,
    input  logic                          ds_allowin,
    output logic [EXC_W+INST_W+PC_W-1:0]  fs_to_ds_bus
);

    import fetch_pkg::*;

    localparam int OUT_W = cnt_width(MAX_OUT);
    localparam int Q_W   = cnt_width(DEPTH);

    logic [OUT_W-1:0]  out_cnt;
    logic [OUT_W-1:0]  out_next;
    logic [OUT_W-1:0]  discard_cnt;
    logic [Q_W-1:0]    q_cnt;
    logic              alloc;
    logic              fill;
    logic              pop;
    logic [EXC_W-1:0]  alloc_exc;
    logic              head_filled;
    logic [EXC_W-1:0]  head_exc;
    logic [INST_W-1:0] head_inst;
    logic [PC_W-1:0]   head_pc;

    // A misaligned fetch address is the only exception raised at this stage.
    always_comb begin
        alloc_exc               = '0;
        alloc_exc[EXC_FLG_ADEF] = |req_pc[1:0];
    end

    assign out_next = out_cnt + OUT_W'(req_fire) - OUT_W'(inst_sram_data_ok);

    assign alloc = req_fire && !flush;
    assign fill  = inst_sram_data_ok && !flush && (discard_cnt == '0);
    assign pop   = fs_to_ds_valid && ds_allowin;

    assign issue_allow = !reset
                      && (int'(out_cnt) < MAX_OUT)
                      && ((int'(q_cnt) + int'(req_fire)) < DEPTH);

    // On a redirect every request still in flight, including one accepted in
    // the flush cycle, belongs to the old stream and must be swallowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt     <= '0;
            discard_cnt <= '0;
        end else begin
            out_cnt <= out_next;
            if (flush) begin
                discard_cnt <= out_next;
            end else if (inst_sram_data_ok && (discard_cnt != '0)) begin
                discard_cnt <= discard_cnt - OUT_W'(1);
            end
        end
    end

    fetch_ring #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .EXC_W  (EXC_W)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .alloc       (alloc),
        .alloc_pc    (req_pc),
        .alloc_exc   (alloc_exc),
        .fill        (fill),
        .fill_inst   (inst_sram_rdata),
        .pop         (pop),
        .flush       (flush),
        .q_cnt       (q_cnt),
        .head_filled (head_filled),
        .head_exc    (head_exc),
        .head_inst   (head_inst),
        .head_pc     (head_pc)
    );

    assign fs_to_ds_valid = (q_cnt != '0) && head_filled && !flush;
    assign fs_to_ds_bus   = {head_exc, head_inst, head_pc};

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed, table-driven bench for if_fetch_queue (DEPTH=4, MAX_OUT=2).
module tb_if_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int EXC_W   = 6;
    localparam int BUS_W   = EXC_W + INST_W + PC_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_allow;
    logic              req_fire;
    logic [PC_W-1:0]   req_pc;
    logic              inst_sram_data_ok;
    logic [INST_W-1:0] inst_sram_rdata;
    logic              flush;
    logic              fs_to_ds_valid;
    logic              ds_allowin;
    logic [BUS_W-1:0]  fs_to_ds_bus;

    typedef struct {
        string       tag;
        bit          rst;
        bit          rf;
        logic [31:0] pc;
        bit          dok;
        logic [31:0] rdata;
        bit          fl;
        bit          ds;
        bit          ia;
        bit          v;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [5:0]  eexc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   bench_out = 0;

    if_fetch_queue #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .PC_W    (PC_W),
        .INST_W  (INST_W),
        .EXC_W   (EXC_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .issue_allow       (issue_allow),
        .req_fire          (req_fire),
        .req_pc            (req_pc),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .flush             (flush),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_bus      (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    // Protocol watchdog: outstanding-request count as seen from the SRAM side.
    always @(posedge clk) begin
        if (reset) begin
            bench_out <= 0;
        end else begin
            assert (!(inst_sram_data_ok && bench_out == 0))
                else $error("[TB] protocol: data_ok with nothing outstanding");
            assert (!(req_fire && bench_out >= MAX_OUT))
                else $error("[TB] protocol: req_fire beyond MAX_OUT");
            bench_out <= bench_out + int'(req_fire) - int'(inst_sram_data_ok);
        end
    end

    function automatic void addv(input string tag, input bit rst, input bit rf,
                                 input logic [31:0] pc, input bit dok,
                                 input logic [31:0] rdata, input bit fl,
                                 input bit ds, input bit ia, input bit v,
                                 input logic [31:0] epc, input logic [31:0] einst,
                                 input logic [5:0] eexc);
        vec_t t;
        t.tag = tag; t.rst = rst; t.rf = rf; t.pc = pc; t.dok = dok;
        t.rdata = rdata; t.fl = fl; t.ds = ds; t.ia = ia; t.v = v;
        t.epc = epc; t.einst = einst; t.eexc = eexc;
        vecs.push_back(t);
    endfunction

    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        reset             = t.rst;
        req_fire          = t.rf;
        req_pc            = t.pc;
        inst_sram_data_ok = t.dok;
        inst_sram_rdata   = t.rdata;
        flush             = t.fl;
        ds_allowin        = t.ds;
    endtask

    task automatic checkOutput(input string tag, input int row, input bit ia,
                               input bit v, input bit chk_bus,
                               input logic [BUS_W-1:0] bus);
        checks++;
        if (issue_allow !== ia) begin
            errors++;
            $display("[TB] FAIL %s[%0d] issue_allow: got %b, expected %b", tag, row, issue_allow, ia);
        end
        checks++;
        if (fs_to_ds_valid !== v) begin
            errors++;
            $display("[TB] FAIL %s[%0d] fs_to_ds_valid: got %b, expected %b", tag, row, fs_to_ds_valid, v);
        end
        if (chk_bus) begin
            checks++;
            if (fs_to_ds_bus !== bus) begin
                errors++;
                $display("[TB] FAIL %s[%0d] fs_to_ds_bus: got %h, expected %h", tag, row, fs_to_ds_bus, bus);
            end
        end
    endtask

    initial begin
        //   tag       rst rf pc            dok rdata         fl ds ia v  epc           einst         exc
        addv("stream", 0, 1, 32'h1c000000, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("stream", 0, 1, 32'h1c000004, 1, 32'ha0000000, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("stream", 0, 1, 32'h1c000008, 1, 32'ha0000001, 0, 1, 1, 1, 32'h1c000000, 32'ha0000000, 6'h00);
        addv("stream", 0, 1, 32'h1c00000c, 1, 32'ha0000002, 0, 1, 1, 1, 32'h1c000004, 32'ha0000001, 6'h00);
        addv("stream", 0, 0, 32'h0,        1, 32'ha0000003, 0, 1, 1, 1, 32'h1c000008, 32'ha0000002, 6'h00);
        addv("stream", 0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c00000c, 32'ha0000003, 6'h00);
        addv("stream", 0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        // Backpressure: decode stalls for 10 cycles, queue fills to DEPTH.
        addv("bp",     0, 1, 32'h1c000010, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("bp",     0, 1, 32'h1c000014, 1, 32'ha0000004, 0, 0, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("bp",     0, 1, 32'h1c000018, 1, 32'ha0000005, 0, 0, 1, 1, 32'h1c000010, 32'ha0000004, 6'h00);
        addv("bp",     0, 1, 32'h1c00001c, 1, 32'ha0000006, 0, 0, 0, 1, 32'h1c000010, 32'ha0000004, 6'h00);
        addv("bp",     0, 0, 32'h0,        1, 32'ha0000007, 0, 0, 0, 1, 32'h1c000010, 32'ha0000004, 6'h00);
        for (int i = 0; i < 5; i++)
            addv("bp", 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h1c000010, 32'ha0000004, 6'h00);
        addv("drain",  0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 1, 32'h1c000010, 32'ha0000004, 6'h00);
        addv("drain",  0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c000014, 32'ha0000005, 6'h00);
        addv("drain",  0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c000018, 32'ha0000006, 6'h00);
        addv("drain",  0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c00001c, 32'ha0000007, 6'h00);
        addv("drain",  0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        // Flush with two outstanding and three queued entries.
        addv("flush",  0, 1, 32'h1c000020, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("flush",  0, 1, 32'h1c000024, 1, 32'ha0000008, 0, 0, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("flush",  0, 1, 32'h1c000028, 0, 32'h0,        0, 0, 1, 1, 32'h1c000020, 32'ha0000008, 6'h00);
        addv("flush",  0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,        32'h0,        6'h00);
        addv("flush",  0, 0, 32'h0,        1, 32'hdead0001, 0, 1, 0, 0, 32'h0,        32'h0,        6'h00);
        addv("flush",  0, 1, 32'h1c000100, 1, 32'hdead0002, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("flush",  0, 0, 32'h0,        1, 32'hb0000100, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("flush",  0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c000100, 32'hb0000100, 6'h00);
        // Flush together with req_fire and data_ok.
        addv("simul",  0, 1, 32'h1c00002c, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("simul",  0, 1, 32'h1c000030, 1, 32'ha0000009, 1, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("simul",  0, 1, 32'h1c000200, 1, 32'hdead0003, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("simul",  0, 0, 32'h0,        1, 32'hb0000200, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("simul",  0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c000200, 32'hb0000200, 6'h00);
        // Back-to-back flushes must not double count stale responses.
        addv("b2b",    0, 1, 32'h1c000300, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("b2b",    0, 1, 32'h1c000304, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("b2b",    0, 0, 32'h0,        1, 32'hdead0004, 1, 1, 0, 0, 32'h0,        32'h0,        6'h00);
        addv("b2b",    0, 0, 32'h0,        1, 32'hdead0005, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("b2b",    0, 1, 32'h1c000308, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("b2b",    0, 0, 32'h0,        1, 32'hb0000308, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("b2b",    0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c000308, 32'hb0000308, 6'h00);
        // Misaligned fetch raises ADEF only.
        addv("adef",   0, 1, 32'h1c000002, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("adef",   0, 0, 32'h0,        1, 32'hb0004002, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("adef",   0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c000002, 32'hb0004002, 6'h01);
        // Reset with a pending discard and a queued entry.
        addv("rst",    0, 1, 32'h1c000400, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("rst",    0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("rst",    0, 1, 32'h1c000404, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("rst",    1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        6'h00);
        addv("rst",    0, 1, 32'h1c000500, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("rst",    0, 0, 32'h0,        1, 32'hb0000500, 0, 1, 1, 0, 32'h0,        32'h0,        6'h00);
        addv("rst",    0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1, 32'h1c000500, 32'hb0000500, 6'h00);

        reset             = 1'b1;
        req_fire          = 1'b0;
        req_pc            = '0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
        flush             = 1'b0;
        ds_allowin        = 1'b0;

        // Hand sequence: reset state, then release.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset", 0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset", 0, 1'b1, 1'b0, 1'b0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i].tag, i, vecs[i].ia, vecs[i].v, vecs[i].v,
                        {vecs[i].eexc, vecs[i].einst, vecs[i].epc});
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
